object_pixel_resolver: RTL and testbench
========================================

Name: object_pixel_resolver

Overview:
- Read side of the object table: consumes the packed per-object state table and answers per-pixel queries from the VGA scan.
- For each requested (x,y): which object covers it (fixed priority), that object's img_id, and the pixel offset inside the object. Feeds the bitmap/ROM fetch stage.
- Accumulates per-frame player-overlap flags for collision logic.
- The table is snapshotted at frame_start, so game-logic updates never tear a frame.

Parameters:
- NUM_OBJ, 4, objects in the table. The table has 5*NUM_OBJ fields.
- FIELD_W, 11, width of every table field and coordinate.
- PLAYER_IDX, 0, object checked against all others for collision.

Ports:
- clk  in  1  pixel/system clock
- resetN  in  1  reset, asynchronous, active-low
- frame_start  in  1  one-cycle pulse at start of frame
- obj_table  in  [0:5*NUM_OBJ-1][0:FIELD_W-1]  live table. Object k occupies fields 5k..5k+4: img_id, x, y, width, height.
- req_valid  in  1  pixel query valid
- requested_x  in  FIELD_W  query x
- requested_y  in  FIELD_W  query y
- out_valid  out  1  result valid
- out_hit  out  1  some enabled object covers the pixel
- out_obj_idx  out  2  winning object index
- out_img_id  out  FIELD_W  winner's img_id
- out_x_offset  out  FIELD_W  requested_x minus winner x
- out_y_offset  out  FIELD_W  requested_y minus winner y
- out_hit_mask  out  NUM_OBJ  all objects covering the pixel; bit k = object k
- collision_mask  out  NUM_OBJ  objects that overlapped the player on some queried pixel in the last completed frame; PLAYER_IDX bit always 0
- collision_pulse  out  1  one cycle: completed frame had a nonzero collision mask

Behaviour:
- Reset, asynchronous: every output is 0. Shadow table, accumulator and pipeline valids are 0. A zero shadow means all objects are disabled, so there are no hits until the first frame_start. Reset mid-pipeline drops in-flight requests; no out_valid follows.
- Snapshot: on a posedge with frame_start=1, shadow <= obj_table. A query accepted in that same cycle still uses the old shadow. Changes to obj_table between frame_starts have no effect.
- Object enable: enabled iff width != 0 and height != 0.
- Hit test: x <= rx < x+width and y <= ry < y+height.
  - The sum is computed at FIELD_W+1 bits. There is no wrap-around: x=2040, w=16 covers 2040..2047 only.
  - Comparisons are unsigned.
- Pipeline: fixed latency 2, no backpressure.
  - Stage 1 registers the per-object hit vector and the request.
  - Stage 2 priority-encodes (lowest index wins), selects the winner's fields, subtracts offsets (FIELD_W bits, modulo), and registers the outputs.
  - out_valid = req_valid delayed 2 cycles. Back-to-back requests give back-to-back results.
- Miss outputs: when out_valid=1 and out_hit=0, out_obj_idx, out_img_id and the offsets are 0, and out_hit_mask = 0.
- Hold: when out_valid=0, all out_* hold their previous values.
- Collision accumulator:
  - On each stage-2 valid result with mask[PLAYER_IDX]=1, acc |= mask with the PLAYER_IDX bit cleared.
  - On frame_start: collision_mask <= acc OR this cycle's contribution; acc <= 0.
  - collision_pulse = 1 for that single cycle iff the value loaded is nonzero; otherwise 0.
  - Results in flight across frame_start: a result emerging in the frame_start cycle belongs to the completed frame. Later results belong to the new frame.

Decomposition:
- Shared package obj_table_pkg holds:
  - FIELD_W and NUM_OBJ.
  - Field index constants F_IMG=0, F_X=1, F_Y=2, F_W=3, F_H=4, FIELDS_PER_OBJ=5.
  - A typedef obj_rec_t (struct of five FIELD_W fields).
  - A function extracting obj_rec_t k from the packed table.
- The object_table writer side uses the same package.
- One sub-module, obj_hit_test: a single object's enable and in-box compare, instantiated NUM_OBJ times in stage 1.

Test Plan:
- Basic hit/miss: player {0,300,7,16,32}, other objects w=0, frame_start, then query (300,7).
  - -> 2 cycles later: hit=1, idx=0, offsets (0,0).
  - (315,38) -> offsets (15,31).
  - (316,7) -> hit=0, mask=0000.
- Priority/collision: car {5,305,10,16,32} plus player as above, frame_start, query (306,12).
  - -> idx=0, img=0, mask=0011.
  - Next frame_start -> collision_mask=0010, collision_pulse=1 for one cycle.
  - Following frame with no overlap -> mask=0000, pulse=0.
- Snapshot isolation: change player x to 100 without frame_start, query (300,7) -> still hit idx 0.
  - Query in the frame_start cycle itself -> old table.
  - Query the next cycle -> (300,7) misses.
- Edge/no-wrap: obj {9,2040,0,16,1}; (2047,0) -> hit, offset 7; (0,0) -> miss. Width 0 object over the pixel -> never hits.
- Streaming: 8 consecutive req_valid cycles -> 8 consecutive out_valid cycles at +2, results in order.
- Reset mid-flight: assert resetN=0 with 2 requests in flight -> all outputs 0 immediately, no out_valid after release, no hits until frame_start.

Source files
------------

// File: rtl/obj_table_pkg.sv
// Shared object-table layout: field positions, per-object record and extraction helper.
// Used by both the table writer and the pixel resolver.
package obj_table_pkg;

   localparam int FIELD_W        = 11;
   localparam int NUM_OBJ        = 4;
   localparam int F_IMG          = 0;
   localparam int F_X            = 1;
   localparam int F_Y            = 2;
   localparam int F_W            = 3;
   localparam int F_H            = 4;
   localparam int FIELDS_PER_OBJ = 5;
   localparam int TBL_IDX_W      = $clog2(FIELDS_PER_OBJ * NUM_OBJ);

   typedef logic [FIELDS_PER_OBJ*NUM_OBJ-1:0][FIELD_W-1:0] obj_table_t;

   typedef struct packed {
      logic [FIELD_W-1:0] img_id;
      logic [FIELD_W-1:0] x;
      logic [FIELD_W-1:0] y;
      logic [FIELD_W-1:0] width;
      logic [FIELD_W-1:0] height;
   } obj_rec_t;

   function automatic obj_rec_t get_obj(input obj_table_t tbl, input int k);
      obj_rec_t rec;
      rec.img_id = tbl[TBL_IDX_W'(FIELDS_PER_OBJ*k + F_IMG)];
      rec.x      = tbl[TBL_IDX_W'(FIELDS_PER_OBJ*k + F_X)];
      rec.y      = tbl[TBL_IDX_W'(FIELDS_PER_OBJ*k + F_Y)];
      rec.width  = tbl[TBL_IDX_W'(FIELDS_PER_OBJ*k + F_W)];
      rec.height = tbl[TBL_IDX_W'(FIELDS_PER_OBJ*k + F_H)];
      return rec;
   endfunction

endpackage

// File: rtl/obj_hit_test.sv
// One object's enable and in-box test against a pixel; purely combinational.
// Box ends are computed one bit wider so objects at the right/bottom edge never wrap to 0.
module obj_hit_test
   import obj_table_pkg::*;
(
   input  obj_rec_t           obj,
   input  logic [FIELD_W-1:0] rx,
   input  logic [FIELD_W-1:0] ry,
   output logic               hit
);

   logic               enabled;
   logic [FIELD_W:0]   x_end;
   logic [FIELD_W:0]   y_end;

   assign enabled = (obj.width != '0) && (obj.height != '0);
   assign x_end   = {1'b0, obj.x} + {1'b0, obj.width};
   assign y_end   = {1'b0, obj.y} + {1'b0, obj.height};

   assign hit = enabled
             && (rx >= obj.x) && ({1'b0, rx} < x_end)
             && (ry >= obj.y) && ({1'b0, ry} < y_end);

endmodule

// File: rtl/object_pixel_resolver.sv
// Per-pixel object lookup over a frame-snapshotted table: 2-cycle fixed latency, no backpressure.
// Also accumulates player-overlap flags per frame and reports them at the next frame_start.
module object_pixel_resolver #(
   parameter int NUM_OBJ    = obj_table_pkg::NUM_OBJ,
   parameter int FIELD_W    = obj_table_pkg::FIELD_W,
   parameter int PLAYER_IDX = 0
) (
   input  logic                                                  clk,
   input  logic                                                  resetN,
   input  logic                                                  frame_start,
   input  logic [obj_table_pkg::FIELDS_PER_OBJ*NUM_OBJ-1:0][FIELD_W-1:0] obj_table,
   input  logic                                                  req_valid,
   input  logic [FIELD_W-1:0]                                    requested_x,
   input  logic [FIELD_W-1:0]                                    requested_y,
   output logic                                                  out_valid,
   output logic                                                  out_hit,
   output logic [1:0]                                            out_obj_idx,
   output logic [FIELD_W-1:0]                                    out_img_id,
   output logic [FIELD_W-1:0]                                    out_x_offset,
   output logic [FIELD_W-1:0]                                    out_y_offset,
   output logic [NUM_OBJ-1:0]                                    out_hit_mask,
   output logic [NUM_OBJ-1:0]                                    collision_mask,
   output logic                                                  collision_pulse
);
   import obj_table_pkg::*;

   obj_table_t          shadow;
   obj_rec_t            obj [NUM_OBJ];
   logic [NUM_OBJ-1:0]  hit_vec;

   logic                s1_vld;
   logic [NUM_OBJ-1:0]  s1_hit;
   logic [FIELD_W-1:0]  s1_rx;
   logic [FIELD_W-1:0]  s1_ry;
   logic [FIELD_W-1:0]  s1_img [NUM_OBJ];
   logic [FIELD_W-1:0]  s1_x   [NUM_OBJ];
   logic [FIELD_W-1:0]  s1_y   [NUM_OBJ];

   logic [1:0]          win;
   logic [NUM_OBJ-1:0]  acc;
   logic [NUM_OBJ-1:0]  contrib;
   logic [NUM_OBJ-1:0]  loaded;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         shadow <= '0;
      else if (frame_start)
         shadow <= obj_table;
   end

   for (genvar k = 0; k < NUM_OBJ; k++) begin : g_obj
      assign obj[k] = get_obj(shadow, k);
      obj_hit_test u_hit (
         .obj (obj[k]),
         .rx  (requested_x),
         .ry  (requested_y),
         .hit (hit_vec[k])
      );
   end

   // Winner fields are captured here so a frame_start between stages cannot tear a result.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         s1_vld <= 1'b0;
         s1_hit <= '0;
         s1_rx  <= '0;
         s1_ry  <= '0;
         for (int i = 0; i < NUM_OBJ; i++) begin
            s1_img[i] <= '0;
            s1_x[i]   <= '0;
            s1_y[i]   <= '0;
         end
      end else begin
         s1_vld <= req_valid;
         if (req_valid) begin
            s1_hit <= hit_vec;
            s1_rx  <= requested_x;
            s1_ry  <= requested_y;
            for (int i = 0; i < NUM_OBJ; i++) begin
               s1_img[i] <= obj[i].img_id;
               s1_x[i]   <= obj[i].x;
               s1_y[i]   <= obj[i].y;
            end
         end
      end
   end

   always_comb begin
      win = '0;
      for (int i = NUM_OBJ - 1; i >= 0; i--)
         if (s1_hit[i]) win = 2'(i);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         out_valid    <= 1'b0;
         out_hit      <= 1'b0;
         out_obj_idx  <= '0;
         out_img_id   <= '0;
         out_x_offset <= '0;
         out_y_offset <= '0;
         out_hit_mask <= '0;
      end else begin
         out_valid <= s1_vld;
         if (s1_vld) begin
            out_hit      <= |s1_hit;
            out_hit_mask <= s1_hit;
            if (|s1_hit) begin
               out_obj_idx  <= win;
               out_img_id   <= s1_img[win];
               out_x_offset <= s1_rx - s1_x[win];
               out_y_offset <= s1_ry - s1_y[win];
            end else begin
               out_obj_idx  <= '0;
               out_img_id   <= '0;
               out_x_offset <= '0;
               out_y_offset <= '0;
            end
         end
      end
   end

   // The result currently on the outputs counts toward the frame that ends this cycle.
   always_comb begin
      contrib = '0;
      if (out_valid && out_hit_mask[PLAYER_IDX]) begin
         contrib             = out_hit_mask;
         contrib[PLAYER_IDX] = 1'b0;
      end
   end

   assign loaded = acc | contrib;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         acc             <= '0;
         collision_mask  <= '0;
         collision_pulse <= 1'b0;
      end else if (frame_start) begin
         acc             <= '0;
         collision_mask  <= loaded;
         collision_pulse <= |loaded;
      end else begin
         acc             <= loaded;
         collision_pulse <= 1'b0;
      end
   end

endmodule

// File: tb/tb_object_pixel_resolver.sv
// Directed test-plan steps followed by random tables/queries, compared each cycle
// against a frame-level reference model of the resolver.
module tb_object_pixel_resolver;

   localparam int N  = 4;
   localparam int FW = 11;

   logic                 clk = 1'b0;
   logic                 resetN = 1'b0;
   logic                 frame_start = 1'b0;
   logic [5*N-1:0][FW-1:0] obj_table = '0;
   logic                 req_valid = 1'b0;
   logic [FW-1:0]        requested_x = '0;
   logic [FW-1:0]        requested_y = '0;
   logic                 out_valid;
   logic                 out_hit;
   logic [1:0]           out_obj_idx;
   logic [FW-1:0]        out_img_id;
   logic [FW-1:0]        out_x_offset;
   logic [FW-1:0]        out_y_offset;
   logic [N-1:0]         out_hit_mask;
   logic [N-1:0]         collision_mask;
   logic                 collision_pulse;

   object_pixel_resolver #(.NUM_OBJ(N), .FIELD_W(FW), .PLAYER_IDX(0)) dut (
      .clk             (clk),
      .resetN          (resetN),
      .frame_start     (frame_start),
      .obj_table       (obj_table),
      .req_valid       (req_valid),
      .requested_x     (requested_x),
      .requested_y     (requested_y),
      .out_valid       (out_valid),
      .out_hit         (out_hit),
      .out_obj_idx     (out_obj_idx),
      .out_img_id      (out_img_id),
      .out_x_offset    (out_x_offset),
      .out_y_offset    (out_y_offset),
      .out_hit_mask    (out_hit_mask),
      .collision_mask  (collision_mask),
      .collision_pulse (collision_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit vld;
      bit hit;
      int idx;
      int img;
      int xo;
      int yo;
      int mask;
   } res_t;

   int   checks = 0;
   int   errors = 0;
   int   live [N][5];
   int   msh  [N][5];
   res_t p1;
   res_t eo;
   int   acc_m;
   int   e_cmask;
   bit   e_pulse;
   int   vcount;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference lookup: scan objects in index order over the frame's table.
   function automatic res_t ref_query(input int rx, input int ry);
      res_t r;
      r = '{default: 0};
      r.vld = 1'b1;
      for (int k = 0; k < N; k++) begin
         int x = msh[k][1];
         int y = msh[k][2];
         int w = msh[k][3];
         int h = msh[k][4];
         if (w != 0 && h != 0 && rx >= x && rx < x + w && ry >= y && ry < y + h) begin
            r.mask |= (1 << k);
            if (!r.hit) begin
               r.hit = 1'b1;
               r.idx = k;
               r.img = msh[k][0];
               r.xo  = (rx - x) & 2047;
               r.yo  = (ry - y) & 2047;
            end
         end
      end
      return r;
   endfunction

   task automatic model_reset();
      p1 = '{default: 0};
      eo = '{default: 0};
      acc_m = 0;
      e_cmask = 0;
      e_pulse = 1'b0;
      for (int k = 0; k < N; k++)
         for (int f = 0; f < 5; f++) msh[k][f] = 0;
   endtask

   task automatic compare_all();
      check("out_valid", int'(out_valid), int'(eo.vld));
      check("out_hit", int'(out_hit), int'(eo.hit));
      check("out_obj_idx", int'(out_obj_idx), eo.idx);
      check("out_img_id", int'(out_img_id), eo.img);
      check("out_x_offset", int'(out_x_offset), eo.xo);
      check("out_y_offset", int'(out_y_offset), eo.yo);
      check("out_hit_mask", int'(out_hit_mask), eo.mask);
      check("collision_mask", int'(collision_mask), e_cmask);
      check("collision_pulse", int'(collision_pulse), int'(e_pulse));
   endtask

   task automatic tick();
      res_t r;
      for (int k = 0; k < N; k++)
         for (int f = 0; f < 5; f++) obj_table[5*k+f] = FW'(live[k][f]);
      if (resetN) begin
         if (req_valid) r = ref_query(int'(requested_x), int'(requested_y));
         else           r = '{default: 0};
         if (eo.vld && (eo.mask & 1) != 0) acc_m |= (eo.mask & ~1);
         if (frame_start) begin
            e_cmask = acc_m;
            e_pulse = (acc_m != 0);
            acc_m   = 0;
            msh     = live;
         end else begin
            e_pulse = 1'b0;
         end
         if (p1.vld) eo = p1;
         else        eo.vld = 1'b0;
         p1 = r;
      end
      @(posedge clk);
      #1;
      if (out_valid) vcount++;
      compare_all();
   endtask

   task automatic req(input int x, input int y);
      req_valid   = 1'b1;
      requested_x = FW'(x);
      requested_y = FW'(y);
   endtask

   task automatic set_obj(input int k, input int img, input int x, input int y, input int w, input int h);
      live[k][0] = img; live[k][1] = x; live[k][2] = y; live[k][3] = w; live[k][4] = h;
   endtask

   initial begin
      for (int k = 0; k < N; k++) set_obj(k, 0, 0, 0, 0, 0);
      model_reset();
      vcount = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      resetN = 1'b1;

      // Basic hit/miss
      set_obj(0, 0, 300, 7, 16, 32);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      req(300, 7);  tick();
      req(315, 38); tick();
      check("basic_hit", int'(out_hit), 1);
      check("basic_xoff0", int'(out_x_offset), 0);
      req(316, 7);  tick();
      check("basic_xoff15", int'(out_x_offset), 15);
      check("basic_yoff31", int'(out_y_offset), 31);
      req_valid = 1'b0; tick();
      check("basic_miss", int'(out_hit), 0);
      check("basic_miss_mask", int'(out_hit_mask), 0);

      // Priority and collision
      set_obj(1, 5, 305, 10, 16, 32);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      req(306, 12); tick();
      req_valid = 1'b0; tick();
      check("prio_idx", int'(out_obj_idx), 0);
      check("prio_mask", int'(out_hit_mask), 3);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      check("coll_mask", int'(collision_mask), 2);
      check("coll_pulse", int'(collision_pulse), 1);
      tick();
      check("coll_pulse_one", int'(collision_pulse), 0);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      check("coll_clear", int'(collision_mask), 0);

      // Snapshot isolation
      live[0][1] = 100;
      req(300, 7); tick();
      req_valid = 1'b0; tick();
      check("snap_old", int'(out_hit), 1);
      req(300, 7); frame_start = 1'b1; tick(); frame_start = 1'b0;
      req(300, 7); tick();
      check("snap_fs_cycle", int'(out_hit), 1);
      req_valid = 1'b0; tick();
      check("snap_new", int'(out_hit), 0);

      // Edge / no-wrap / disabled object
      set_obj(2, 9, 2040, 0, 16, 1);
      set_obj(3, 3, 0, 0, 0, 5);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      req(2047, 0); tick();
      req(0, 0);    tick();
      check("edge_idx", int'(out_obj_idx), 2);
      check("edge_xoff", int'(out_x_offset), 7);
      req_valid = 1'b0; tick();
      check("nowrap_miss", int'(out_hit), 0);

      // Streaming
      vcount = 0;
      for (int i = 0; i < 8; i++) begin
         req(2040 + i, 0); tick();
      end
      req_valid = 1'b0;
      repeat (3) tick();
      check("stream_count", vcount, 8);

      // Reset with requests in flight
      req(2047, 0); tick();
      req(2041, 0); tick();
      resetN = 1'b0;
      model_reset();
      #1;
      compare_all();
      req_valid = 1'b0;
      tick(); tick();
      resetN = 1'b1;
      vcount = 0;
      repeat (3) tick();
      check("rst_no_valid", vcount, 0);
      req(2047, 0); tick();
      req_valid = 1'b0; tick();
      check("rst_no_hit", int'(out_hit), 0);

      // Random tables, frames and queries
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 19) == 0) begin
            for (int k = 0; k < N; k++) begin
               live[k][0] = $urandom_range(0, 2047);
               live[k][1] = ($urandom_range(0, 7) == 0) ? $urandom_range(2030, 2047) : $urandom_range(0, 60);
               live[k][2] = $urandom_range(0, 60);
               live[k][3] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 24);
               live[k][4] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 24);
            end
         end
         frame_start = ($urandom_range(0, 15) == 0);
         req_valid   = ($urandom_range(0, 3) != 0);
         requested_x = ($urandom_range(0, 7) == 0) ? FW'($urandom_range(2030, 2047)) : FW'($urandom_range(0, 80));
         requested_y = FW'($urandom_range(0, 80));
         tick();
      end
      frame_start = 1'b0;
      req_valid   = 1'b0;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
